// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves RV64 conditional branches on forwarded EX operands and reports
// mispredictions. A table of 2-bit saturating counters supplies fetch-stage
// predictions. Two saturating performance counters track resolved branches
// and mispredictions.
module branch_resolve_unit #(
    parameter int XLEN      = 64,
    parameter int PC_W      = 64,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PC_W-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic             ex_pred_taken,
    input  logic             clr_counts,
    output logic             res_valid,
    output logic             res_taken,
    output logic             mispredict,
    output logic             illegal_br,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             br_event;
    logic             br_legal;
    logic             br_taken;
    logic             legal_event;
    logic             mispred_now;
    logic [1:0]       cur_ctr;
    logic [1:0]       nxt_ctr;

    // PC bits outside the index field do not take part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                              ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // The lookup reads the stored entry, so a same-cycle update is not visible.
    assign if_pred_taken = bht[if_idx][1];

    // Decode the branch type and evaluate its condition at full operand width.
    always_comb begin
        br_taken = 1'b0;
        br_legal = 1'b1;
        case (ex_funct3)
            3'b000:  br_taken = (ex_rs1 == ex_rs2);
            3'b001:  br_taken = (ex_rs1 != ex_rs2);
            3'b100:  br_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  br_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  br_taken = (ex_rs1 <  ex_rs2);
            3'b111:  br_taken = (ex_rs1 >= ex_rs2);
            default: begin
                br_taken = 1'b0;
                br_legal = 1'b0;
            end
        endcase
    end

    assign br_event    = ex_valid & ex_is_branch;
    assign legal_event = br_event & br_legal;
    // A reserved type resolves as not-taken, so a taken prediction mispredicts.
    assign mispred_now = br_event & (br_taken ^ ex_pred_taken);

    // Saturating step of the counter for the resolving branch.
    always_comb begin
        cur_ctr = bht[ex_idx];
        nxt_ctr = cur_ctr;
        if (br_taken) begin
            if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
        end
    end

    // Prediction table: weakly not-taken after reset, trained by legal branches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (legal_event) begin
            bht[ex_idx] <= nxt_ctr;
        end
    end

    // Registered resolution outputs; pulses last exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid  <= 1'b0;
            res_taken  <= 1'b0;
            mispredict <= 1'b0;
            illegal_br <= 1'b0;
        end else begin
            res_valid  <= br_event;
            mispredict <= mispred_now;
            illegal_br <= br_event & ~br_legal;
            if (br_event) res_taken <= br_taken;
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else if (clr_counts) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            if (legal_event && (branch_count != '1))
                branch_count <= branch_count + CNT_W'(1);
            if (mispred_now && (mispred_count != '1))
                mispred_count <= mispred_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus random traffic,
// compared against a behavioural model of the predictor and counters.
module tb_branch_resolve_unit;

    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [63:0] ex_pc;
    logic [2:0]  ex_funct3;
    logic [63:0] ex_rs1;
    logic [63:0] ex_rs2;
    logic        ex_pred_taken;
    logic        clr_counts;
    logic        res_valid;
    logic        res_taken;
    logic        mispredict;
    logic        illegal_br;
    logic [3:0]  branch_count;
    logic [3:0]  mispred_count;

    branch_resolve_unit #(
        .XLEN(64), .PC_W(64), .BHT_DEPTH(16), .CNT_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pred_taken(ex_pred_taken), .clr_counts(clr_counts),
        .res_valid(res_valid), .res_taken(res_taken),
        .mispredict(mispredict), .illegal_br(illegal_br),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: per-entry strength 0..3, counts, last direction.
    int m_bht [16];
    int m_bc;
    int m_mc;
    bit m_rt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [63:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic bit ref_taken(input logic [2:0] f, input logic [63:0] a,
                                     input logic [63:0] b, output bit legal);
        longint sa = a;
        longint sb = b;
        legal = 1'b1;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: begin
                legal = 1'b0;
                return 1'b0;
            end
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
        m_rt = 1'b0;
    endtask

    // One cycle: drive after a falling edge, check the lookup, clock, check results.
    task automatic step(input bit v, input bit br, input logic [63:0] pc,
                        input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        input bit pred, input bit clr, input logic [63:0] ipc);
        bit ev, legal, tk, mis;
        ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_funct3 = f;
        ex_rs1 = a; ex_rs2 = b; ex_pred_taken = pred; clr_counts = clr; if_pc = ipc;
        #1;
        chk("if_pred_taken", if_pred_taken, m_bht[idx_of(ipc)] >= 2);
        ev  = v && br;
        tk  = ref_taken(f, a, b, legal);
        mis = ev && (tk != pred);
        if (ev) m_rt = tk;
        if (ev && legal) begin
            if (tk) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 3) ? 3 : m_bht[idx_of(pc)] + 1;
            else    m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 0) ? 0 : m_bht[idx_of(pc)] - 1;
        end
        if (clr) begin
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (ev && legal && m_bc < CNT_MAX) m_bc++;
            if (mis && m_mc < CNT_MAX) m_mc++;
        end
        @(posedge clk);
        #1;
        chk("res_valid", res_valid, ev);
        chk("res_taken", res_taken, m_rt);
        chk("mispredict", mispredict, mis);
        chk("illegal_br", illegal_br, ev && !legal);
        chk("branch_count", branch_count, m_bc);
        chk("mispred_count", mispred_count, m_mc);
        @(negedge clk);
    endtask

    task automatic idle(input logic [63:0] ipc);
        step(0, 0, 64'h0, 3'd0, 64'h0, 64'h0, 0, 0, ipc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_taken"}, res_taken, 0);
        chk({tag, "_mispredict"}, mispredict, 0);
        chk({tag, "_illegal_br"}, illegal_br, 0);
        chk({tag, "_branch_count"}, branch_count, 0);
        chk({tag, "_mispred_count"}, mispred_count, 0);
    endtask

    initial begin
        bit exp_cmp [6];
        logic [2:0] f3s [6];
        logic [63:0] ra, rb, rpc;
        logic [2:0] rf;

        exp_cmp = '{0, 1, 1, 0, 0, 1};
        f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        reset_n = 1'b0;
        ex_valid = 0; ex_is_branch = 0; ex_pc = '0; ex_funct3 = '0;
        ex_rs1 = '0; ex_rs2 = '0; ex_pred_taken = 0; clr_counts = 0;
        if_pc = 64'h1000;
        model_reset();
        #3;
        chk("reset_if_pred_taken", if_pred_taken, 0);
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(64'h1000);

        // All compare types with rs1 = -1, rs2 = 1.
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 64'h104, f3s[i], 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h1000);
            chk($sformatf("cmp_f3_%0d", f3s[i]), res_taken, exp_cmp[i]);
        end

        // Saturation at pc 0x40: three taken, then three not-taken.
        for (int i = 0; i < 3; i++) step(1, 1, 64'h40, 3'd0, 64'h5, 64'h5, 1, 0, 64'h40);
        idle(64'h40);
        chk("sat_high_pred", if_pred_taken, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 64'h40, 3'd0, 64'h5, 64'h6, 0, 0, 64'h40);
        idle(64'h40);
        chk("sat_low_pred", if_pred_taken, 0);

        // Mispredict and aliasing 0x40 / 0x80.
        step(0, 0, 64'h0, 3'd0, 64'h0, 64'h0, 0, 1, 64'h80);
        step(1, 1, 64'h40, 3'd1, 64'h1, 64'h2, 0, 0, 64'h80);
        chk("mp_pulse", mispredict, 1);
        chk("mp_count_one", mispred_count, 1);
        step(1, 1, 64'h40, 3'd1, 64'h1, 64'h2, 0, 0, 64'h80);
        chk("mp_back_to_back", mispredict, 1);
        idle(64'h80);
        chk("alias_pred_0x80", if_pred_taken, 1);

        // Reserved funct3 with a taken prediction.
        step(1, 1, 64'h40, 3'd2, 64'h7, 64'h7, 1, 0, 64'h40);
        chk("ill_flag", illegal_br, 1);
        chk("ill_mispredict", mispredict, 1);
        chk("ill_res_taken", res_taken, 0);
        idle(64'h40);

        // Counter saturation then clear together with a branch.
        for (int i = 0; i < 20; i++)
            step(1, 1, 64'(i * 4), 3'd0, 64'(i), 64'(i), 1, 0, 64'h0);
        chk("bc_saturated", branch_count, 15);
        step(1, 1, 64'h8, 3'd1, 64'h1, 64'h2, 0, 1, 64'h8);
        chk("bc_cleared", branch_count, 0);
        chk("mc_cleared", mispred_count, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            ra  = {$urandom, $urandom};
            rb  = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ra ^ 64'h8000_0000_0000_0000;
            rf  = 3'($urandom_range(0, 7));
            rpc = 64'($urandom_range(0, 255)) << 2;
            step($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, rpc, rf, ra, rb,
                 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
                 64'($urandom_range(0, 255)) << 2);
        end

        // Reset mid-operation discards the in-flight resolution.
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'd1; ex_rs1 = 64'h1; ex_rs2 = 64'h2;
        ex_pred_taken = 0; ex_pc = 64'h40;
        #2;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("midreset");
        ex_valid = 0; ex_is_branch = 0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(64'h40);
        chk("post_reset_no_pulse", mispredict, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
